// File: rtl/wallace_mult_pipe_if.sv
// Operand/result handshake bundle for wallace_mult_pipe.
interface wallace_mult_pipe_if #(
   parameter int unsigned WIDTH = 6
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in1;
   logic [WIDTH-1:0]     in2;
   logic                 approx_en;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out;
   logic                 out_approx;

   // Operand source / result sink side.
   modport master (
      output in_valid, in1, in2, approx_en, out_ready,
      input  in_ready, out_valid, out, out_approx
   );

   // Multiplier side.
   modport slave (
      input  in_valid, in1, in2, approx_en, out_ready,
      output in_ready, out_valid, out, out_approx
   );
endinterface

// File: rtl/wallace_mult_pipe.sv
// Pipelined unsigned WIDTH x WIDTH Wallace-tree multiplier with optional
// carry-free OR approximation of the low APPROX_COLS product columns.
module wallace_mult_pipe #(
   parameter int unsigned WIDTH       = 6,
   parameter int unsigned PIPE_STAGES = 2,
   parameter int unsigned APPROX_COLS = 4
) (
   input logic               clk,
   input logic               rst_n,
   wallace_mult_pipe_if.slave bus
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned NR = (WIDTH < 2) ? 2 : WIDTH;

   // One partial-product / partial-sum row per entry, each a full product-width vector.
   typedef logic [NR-1:0][PW-1:0] rows_t;

   // Number of live rows after lvl reduction levels.
   function automatic int rows_after(input int lvl);
      int n;
      n = int'(WIDTH);
      for (int l = 0; l < lvl; l++) begin
         if (n > 2) n = 2 * (n / 3) + (n % 3);
      end
      return n;
   endfunction

   // Number of 3:2 levels needed to bring WIDTH rows down to two.
   function automatic int count_levels();
      int n;
      int l;
      n = int'(WIDTH);
      l = 0;
      while (n > 2) begin
         n = 2 * (n / 3) + (n % 3);
         l++;
      end
      return l;
   endfunction

   function automatic logic [PW-1:0] low_mask();
      logic [PW-1:0] m;
      m = '0;
      for (int c = 0; c < int'(PW); c++) m[c] = (c < int'(APPROX_COLS));
      return m;
   endfunction

   // One Wallace level: rows grouped in threes through vector full adders, leftovers pass.
   function automatic rows_t csa_level(input rows_t r, input int n);
      rows_t o;
      int    g3;
      o  = '0;
      g3 = n / 3;
      for (int g = 0; g < int'(NR) / 3; g++) begin
         if (g < g3) begin
            o[2*g]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
            o[2*g+1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) |
                        (r[3*g+1] & r[3*g+2])) << 1;
         end
      end
      for (int i = 0; i < int'(NR); i++) begin
         if (i >= 3 * g3 && i < n) o[2*g3 + i - 3*g3] = r[i];
      end
      return o;
   endfunction

   localparam int            LEVELS   = count_levels();
   localparam logic [PW-1:0] LOW_MASK = low_mask();

   logic          advance;
   logic          out_valid_q;
   logic [PW-1:0] out_q;
   logic          out_approx_q;
   rows_t         pp_rows;
   logic [PW-1:0] or_low;

   assign advance      = bus.out_ready || !out_valid_q;
   assign bus.in_ready = advance;

   // Partial products; in approximate mode the low columns collapse to one OR bit each,
   // parked in row 0 where every other row is zero so no carry can start there.
   always_comb begin
      pp_rows = '0;
      or_low  = '0;
      for (int j = 0; j < int'(WIDTH); j++) begin
         pp_rows[j] = PW'(bus.in1 & {WIDTH{bus.in2[j]}}) << j;
         or_low     = or_low | (pp_rows[j] & LOW_MASK);
      end
      if (bus.approx_en) begin
         for (int j = 0; j < int'(WIDTH); j++) pp_rows[j] = pp_rows[j] & ~LOW_MASK;
         pp_rows[0] = pp_rows[0] | or_low;
      end
   end

   for (genvar s = 0; s < int'(PIPE_STAGES); s++) begin : g_stage
      localparam int LO = s * LEVELS / int'(PIPE_STAGES);
      localparam int HI = (s + 1) * LEVELS / int'(PIPE_STAGES);

      rows_t src_rows;
      logic  src_valid;
      logic  src_approx;
      rows_t nxt_rows;
      rows_t rows_q;
      logic  valid_q;
      logic  approx_q;

      if (s == 0) begin : g_src_in
         assign src_rows   = pp_rows;
         assign src_valid  = bus.in_valid;
         assign src_approx = bus.approx_en;
      end else begin : g_src_prev
         assign src_rows   = g_stage[s-1].rows_q;
         assign src_valid  = g_stage[s-1].valid_q;
         assign src_approx = g_stage[s-1].approx_q;
      end

      // This stage's share of the reduction levels.
      always_comb begin
         nxt_rows = src_rows;
         for (int l = LO; l < HI; l++) nxt_rows = csa_level(nxt_rows, rows_after(l));
      end

      // Stage valid bit; cleared by reset so in-flight work is dropped.
      always_ff @(posedge clk) begin
         if (!rst_n)       valid_q <= 1'b0;
         else if (advance) valid_q <= src_valid;
      end

      // Stage payload moves in lockstep with the valid bit, bubbles included.
      always_ff @(posedge clk) begin
         if (advance) begin
            rows_q   <= nxt_rows;
            approx_q <= src_approx;
         end
      end
   end

   rows_t         last_rows;
   logic [PW-1:0] sum_c;

   assign last_rows = g_stage[PIPE_STAGES-1].rows_q;
   assign sum_c     = last_rows[0] + last_rows[1];

   if (NR > 2) begin : g_unused
      logic unused_rows_c;
      assign unused_rows_c = ^last_rows[NR-1:2];
   end

   // Output stage: final carry-propagate add and result register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_q        <= '0;
         out_approx_q <= 1'b0;
      end else if (advance) begin
         out_valid_q  <= g_stage[PIPE_STAGES-1].valid_q;
         out_q        <= sum_c;
         out_approx_q <= g_stage[PIPE_STAGES-1].approx_q;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out        = out_q;
   assign bus.out_approx = out_approx_q;

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Directed and exhaustive checks of wallace_mult_pipe (WIDTH=6, 2 tree stages, 4 approx columns).
module tb_wallace_mult_pipe;

   localparam int unsigned WIDTH       = 6;
   localparam int unsigned PIPE_STAGES = 2;
   localparam int unsigned APPROX_COLS = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   wallace_mult_pipe_if #(.WIDTH(WIDTH)) bus ();

   wallace_mult_pipe #(
      .WIDTH      (WIDTH),
      .PIPE_STAGES(PIPE_STAGES),
      .APPROX_COLS(APPROX_COLS)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Column-counting reference: low columns OR'd, upper columns weighted bit counts.
   function automatic logic [11:0] golden(input int a, input int b, input bit ap);
      int acc;
      int cnt;
      acc = 0;
      for (int c = 0; c < 12; c++) begin
         cnt = 0;
         for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
               if (i + j == c && a[i] && b[j]) cnt++;
         if (ap && c < int'(APPROX_COLS)) acc += ((cnt != 0) ? 1 : 0) << c;
         else                             acc += cnt << c;
      end
      return 12'(acc);
   endfunction

   task automatic drive_idle();
      bus.in_valid  = 1'b0;
      bus.in1       = '0;
      bus.in2       = '0;
      bus.approx_en = 1'b0;
   endtask

   // Presents one operand pair and waits (bounded) for its result with out_ready=1.
   task automatic send_one(input int a, input int b, input bit ap,
                           output logic [11:0] res, output logic rap, output bit got);
      got           = 1'b0;
      res           = '0;
      rap           = 1'b0;
      bus.in1       = 6'(a);
      bus.in2       = 6'(b);
      bus.approx_en = ap;
      bus.in_valid  = 1'b1;
      for (int k = 0; k < 10 && !got; k++) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         if (bus.out_valid === 1'b1) begin
            got = 1'b1;
            res = bus.out;
            rap = bus.out_approx;
         end
      end
   endtask

   task automatic test_reset();
      drive_idle();
      bus.out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
      total++; if (bus.out !== 12'd0) $display("FAIL reset_out: got %0d want 0", bus.out); else passed++;
      total++; if (bus.out_approx !== 1'b0) $display("FAIL reset_out_approx: got %b want 0", bus.out_approx); else passed++;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
   endtask

   task automatic test_exact_latency();
      bus.in1 = 6'd63; bus.in2 = 6'd63; bus.approx_en = 1'b0; bus.in_valid = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         if (k == 1) bus.in_valid = 1'b0;
         total++;
         if (bus.out_valid !== (k == 3)) $display("FAIL latency_edge%0d: out_valid %b want %b", k, bus.out_valid, (k == 3));
         else passed++;
      end
      total++; if (bus.out !== 12'd3969) $display("FAIL exact_63x63: got %0d want 3969", bus.out); else passed++;
      total++; if (bus.out_approx !== 1'b0) $display("FAIL exact_63x63_flag: got %b want 0", bus.out_approx); else passed++;
   endtask

   task automatic test_approx();
      logic [11:0] r;
      logic        ra;
      bit          g;
      send_one(15, 15, 1'b1, r, ra, g);
      total++; if (!g || r !== 12'd191) $display("FAIL approx_15x15: got %0d (seen %0d) want 191", r, g); else passed++;
      total++; if (ra !== 1'b1) $display("FAIL approx_15x15_flag: got %b want 1", ra); else passed++;
      send_one(15, 15, 1'b0, r, ra, g);
      total++; if (!g || r !== 12'd225) $display("FAIL exact_15x15: got %0d (seen %0d) want 225", r, g); else passed++;
      total++; if (ra !== 1'b0) $display("FAIL exact_15x15_flag: got %b want 0", ra); else passed++;
      send_one(63, 63, 1'b1, r, ra, g);
      total++; if (!g || r !== 12'd3935) $display("FAIL approx_63x63: got %0d (seen %0d) want 3935", r, g); else passed++;
      send_one(0, 63, 1'b1, r, ra, g);
      total++; if (!g || r !== 12'd0) $display("FAIL approx_0x63: got %0d (seen %0d) want 0", r, g); else passed++;
   endtask

   task automatic test_back_to_back();
      int          sa [4] = '{0, 1, 63, 42};
      int          sb [4] = '{5, 1, 1, 37};
      logic [11:0] ex [4] = '{12'd0, 12'd1, 12'd63, 12'd1554};
      bus.in1 = 6'(sa[0]); bus.in2 = 6'(sb[0]); bus.approx_en = 1'b0; bus.in_valid = 1'b1;
      for (int cyc = 0; cyc < 7; cyc++) begin
         @(posedge clk); #1;
         if (cyc + 1 < 4) begin
            bus.in1 = 6'(sa[cyc+1]); bus.in2 = 6'(sb[cyc+1]);
         end else begin
            bus.in_valid = 1'b0;
         end
         if (cyc >= 2 && cyc <= 5) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.out !== ex[cyc-2])
               $display("FAIL stream_%0d: valid %b out %0d want valid 1 out %0d", cyc - 2, bus.out_valid, bus.out, ex[cyc-2]);
            else passed++;
         end
         if (cyc == 6) begin
            total++;
            if (bus.out_valid !== 1'b0) $display("FAIL stream_tail: out_valid %b want 0", bus.out_valid); else passed++;
         end
      end
   endtask

   task automatic test_backpressure();
      int          ia [4] = '{3, 4, 5, 6};
      logic [11:0] ex [4] = '{12'd21, 12'd28, 12'd35, 12'd42};
      logic [11:0] rx [$];
      int          sent;
      logic        rdy, ov;
      logic [11:0] ob;
      bit          extra;
      sent = 0;
      bus.out_ready = 1'b0;
      bus.in1 = 6'(ia[0]); bus.in2 = 6'd7; bus.approx_en = 1'b0; bus.in_valid = 1'b1;
      #1 rdy = bus.in_ready; ov = bus.out_valid; ob = bus.out;
      for (int cyc = 0; cyc < 40 && rx.size() < 4; cyc++) begin
         @(posedge clk); #1;
         if (bus.in_valid && rdy) sent++;
         if (ov && bus.out_ready) rx.push_back(ob);
         bus.out_ready = (cyc >= 7);
         bus.in_valid  = (sent < 4);
         if (sent < 4) bus.in1 = 6'(ia[sent]);
         #1 rdy = bus.in_ready; ov = bus.out_valid; ob = bus.out;
         if (cyc >= 2 && cyc <= 6) begin
            total++;
            if (rdy !== 1'b0 || ov !== 1'b1 || ob !== 12'd21)
               $display("FAIL stall_cyc%0d: in_ready %b out_valid %b out %0d want 0 1 21", cyc, rdy, ov, ob);
            else passed++;
         end
      end
      bus.in_valid = 1'b0;
      total++; if (rx.size() != 4) $display("FAIL bp_count: got %0d results want 4", rx.size()); else passed++;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (k >= rx.size() || rx[k] !== ex[k])
            $display("FAIL bp_result_%0d: got %0d want %0d", k, (k < rx.size()) ? rx[k] : 12'hfff, ex[k]);
         else passed++;
      end
      extra = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0) extra = 1'b1;
      end
      total++; if (extra) $display("FAIL bp_duplicate: out_valid %b want 0 after drain", 1'b1); else passed++;
   endtask

   task automatic test_reset_mid();
      bit stale;
      bus.out_ready = 1'b1;
      bus.approx_en = 1'b0;
      bus.in1 = 6'd10; bus.in2 = 6'd10; bus.in_valid = 1'b1;
      @(posedge clk); #1 bus.in1 = 6'd11; bus.in2 = 6'd11;
      @(posedge clk); #1 bus.in1 = 6'd12; bus.in2 = 6'd12;
      @(posedge clk); #1 bus.in_valid = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL midreset_valid: got %b want 0", bus.out_valid); else passed++;
      total++; if (bus.out !== 12'd0) $display("FAIL midreset_out: got %0d want 0", bus.out); else passed++;
      stale = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0) stale = 1'b1;
      end
      total++; if (stale) $display("FAIL midreset_stale: out_valid %b want 0", 1'b1); else passed++;
   endtask

   task automatic test_sweep();
      logic [11:0] eq  [$];
      logic        eap [$];
      int          sent, rcv, idx;
      logic        rdy, ov, oa;
      logic [11:0] ob, e;
      logic        ea;
      sent = 0; rcv = 0; idx = 0;
      bus.in1 = 6'd0; bus.in2 = 6'd0; bus.approx_en = 1'($urandom_range(0, 1));
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      #1 rdy = bus.in_ready; ov = bus.out_valid; ob = bus.out; oa = bus.out_approx;
      for (int cyc = 0; cyc < 30000 && rcv < 4096; cyc++) begin
         @(posedge clk); #1;
         if (bus.in_valid && rdy) begin
            eq.push_back(golden(int'(bus.in1), int'(bus.in2), bus.approx_en));
            eap.push_back(bus.approx_en);
            sent++;
            idx++;
            if (idx < 4096) begin
               bus.in1 = 6'(idx >> 6); bus.in2 = 6'(idx & 63);
               bus.approx_en = 1'($urandom_range(0, 1));
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         if (ov && bus.out_ready) begin
            total++;
            if (eq.size() == 0) begin
               $display("FAIL sweep_unexpected: got %0d with no pending transaction", ob);
            end else begin
               e = eq.pop_front(); ea = eap.pop_front();
               if (ob !== e || oa !== ea)
                  $display("FAIL sweep_%0d: got %0d/%b want %0d/%b", rcv, ob, oa, e, ea);
               else passed++;
            end
            rcv++;
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         #1 rdy = bus.in_ready; ov = bus.out_valid; ob = bus.out; oa = bus.out_approx;
      end
      total++; if (rcv != 4096 || sent != 4096) $display("FAIL sweep_count: got %0d results %0d sent want 4096", rcv, sent); else passed++;
   endtask

   initial begin
      test_reset();
      test_exact_latency();
      test_approx();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_sweep();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
